// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial WIDTH-bit subtractor, D = X - Y (mod 2^WIDTH), LSB first, one
// bit per clock. Each bit is formed by two half-subtractor steps (x0 - y0,
// then minus the running borrow), and the borrow is carried in a flip-flop.
// A start/done handshake frames each operation:
//   IDLE --START--> SHIFT (WIDTH cycles) --> DONE (1 cycle) --> IDLE
// D, B and OVF are registered and only change on the completion edge or reset.
//
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN
//   defined   : OVF reports signed (two's-complement) overflow of X - Y,
//               using operand MSBs latched when START is accepted.
//   undefined : OVF is tied to 0 and no MSB capture logic exists.

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] D,
  output logic             B,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVF
);

  // One spare counter bit keeps the width >= 2 for the smallest WIDTH and
  // leaves headroom for the final increment.
  localparam int            CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Half-subtractor difference: a - b without borrow-in.
  function automatic logic hs_diff(input logic a, input logic b);
    return a ^ b;
  endfunction

  // Half-subtractor borrow-out: set when b > a.
  function automatic logic hs_borrow(input logic a, input logic b);
    return ~a & b;
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] sx_r;
  logic [WIDTH-1:0] sy_r;
  logic [WIDTH-1:0] sr_r;
  logic             br_r;
  logic [CW-1:0]    cnt_r;

  logic             x0_s;
  logic             y0_s;
  logic             d1_s;
  logic             b1_s;
  logic             diff_s;
  logic             b2_s;
  logic             br_next_s;
  logic [WIDTH-1:0] sr_next_s;
  logic             last_s;

  // Per-bit datapath: two cascaded half subtractors and the next result word.
  always_comb begin
    x0_s      = sx_r[0];
    y0_s      = sy_r[0];
    d1_s      = hs_diff(x0_s, y0_s);
    b1_s      = hs_borrow(x0_s, y0_s);
    diff_s    = hs_diff(d1_s, br_r);
    b2_s      = hs_borrow(d1_s, br_r);
    br_next_s = b1_s | b2_s;
    sr_next_s = {diff_s, sr_r[WIDTH-1:1]};
    last_s    = (cnt_r == CNT_LAST);
  end

  // Control FSM with the shift datapath and all registered handshake/result outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_IDLE;
      sx_r    <= {WIDTH{1'b0}};
      sy_r    <= {WIDTH{1'b0}};
      sr_r    <= {WIDTH{1'b0}};
      br_r    <= 1'b0;
      cnt_r   <= CNT_ZERO;
      D       <= {WIDTH{1'b0}};
      B       <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            sx_r    <= X;
            sy_r    <= Y;
            sr_r    <= {WIDTH{1'b0}};
            br_r    <= 1'b0;
            cnt_r   <= CNT_ZERO;
            BUSY    <= 1'b1;
            state_r <= S_SHIFT;
          end else begin
            BUSY    <= 1'b0;
            state_r <= S_IDLE;
          end
        end

        S_SHIFT: begin
          sx_r  <= {1'b0, sx_r[WIDTH-1:1]};
          sy_r  <= {1'b0, sy_r[WIDTH-1:1]};
          sr_r  <= sr_next_s;
          br_r  <= br_next_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (last_s) begin
            // Completion edge: publish the result together with DONE.
            D       <= sr_next_s;
            B       <= br_next_s;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            state_r <= S_DONE;
          end else begin
            BUSY    <= 1'b1;
            DONE    <= 1'b0;
            state_r <= S_SHIFT;
          end
        end

        S_DONE: begin
          // START is deliberately not looked at here; it is never queued.
          BUSY    <= 1'b0;
          DONE    <= 1'b0;
          state_r <= S_IDLE;
        end

        default: begin
          state_r <= S_IDLE;
          BUSY    <= 1'b0;
          DONE    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic xmsb_r;
  logic ymsb_r;
  logic ovf_r;

  // Latch operand signs at acceptance; judge signed overflow on the completion edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      xmsb_r <= 1'b0;
      ymsb_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if ((state_r == S_IDLE) && START) begin
      xmsb_r <= X[WIDTH-1];
      ymsb_r <= Y[WIDTH-1];
    end else if ((state_r == S_SHIFT) && last_s) begin
      // Overflow only when signs differ and the result sign departs from X.
      ovf_r  <= (xmsb_r != ymsb_r) & (sr_next_s[WIDTH-1] != xmsb_r);
    end else begin
      ovf_r  <= ovf_r;
    end
  end

  assign OVF = ovf_r;
`else
  assign OVF = 1'b0;
`endif

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor computing D = X − Y, LSB first, one bit per clock. It applies the half-subtractor difference/borrow equations twice per bit, with a borrow-in, and holds the running borrow in a flip-flop. It is the sequential stage downstream of the gate-level half/full subtractor cells: it consumes their per-bit difference/borrow behaviour and produces a registered multi-bit result with a start/done handshake for the lab datapath.

## Interface

- WIDTH, 8, operand and result width in bits (legal range 2..32)

- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- START  in  1  request; sampled only in IDLE
- X  in  WIDTH  minuend; sampled on the START edge
- Y  in  WIDTH  subtrahend; sampled on the START edge
- D  out  WIDTH  registered difference X − Y mod 2^WIDTH
- B  out  1  registered final borrow; 1 iff X < Y unsigned
- BUSY  out  1  high while bits are being processed
- DONE  out  1  one-cycle pulse; D/B/OVF valid and new
- OVF  out  1  signed (two's-complement) overflow; see Configuration

## Operation

- States: IDLE, SHIFT, DONE.
- IDLE:
  - START=1 loads X and Y into internal shift registers sx and sy.
  - Clears borrow register br and bit counter cnt.
  - Goes to SHIFT.
  - START=0: stay in IDLE.
- SHIFT, each cycle:
  - x0 = sx[0], y0 = sy[0].
  - Bit difference: d = x0 ^ y0 ^ br.
  - Next borrow: br' = (~x0 & y0) | (~(x0 ^ y0) & br).
  - d shifts into the MSB of internal result register sr (right shift). sx and sy shift right.
  - cnt increments.
  - When cnt = WIDTH−1, the same edge also copies the final sr into D, br' into B, and the overflow value into OVF, then goes to DONE.
- DONE: lasts exactly one cycle, then returns unconditionally to IDLE.
- START is ignored in SHIFT and DONE. It is not queued.
- D, B and OVF hold the previous result throughout SHIFT. They change only on the completion edge or on reset.
- Reset values: state IDLE; D=0, B=0, OVF=0, BUSY=0, DONE=0; sx, sy, sr, br and cnt all 0.
- RST has priority over all other activity. A RST asserted mid-operation aborts the operation, and no DONE is produced.

## Timing

- Call the edge that samples START=1 in IDLE edge 0.
- Edges 1..WIDTH each process one bit, LSB first.
- BUSY=1 after edge 0 through edge WIDTH. BUSY=0 after edge WIDTH.
- After edge WIDTH: DONE=1 for exactly one cycle, with the new D, B and OVF.
- After edge WIDTH+1: DONE=0 and the state is IDLE.
- Earliest next accepted START is edge WIDTH+2, giving a throughput of one operation per WIDTH+2 cycles.
- BUSY and DONE are never high together.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration

- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - OVF = (sx_msb_orig != sy_msb_orig) & (D[WIDTH−1] != sx_msb_orig), captured on the completion edge.
  - The operands' MSBs are latched on edge 0.
- Undefined:
  - The OVF port still exists and is tied to constant 0.
  - No MSB capture logic is synthesized.
  - All other behaviour is identical.

## Test plan

- WIDTH=8, X=0x5A, Y=0x3C, START for 1 cycle -> BUSY for 8 cycles, then DONE pulse with D=0x1E, B=0, OVF=0.
- X=0x00, Y=0x01 -> D=0xFF, B=1. Then X=0xFF, Y=0xFF -> D=0x00, B=0. This also checks back-to-back START at the earliest legal edge (WIDTH+2).
- START held high for the whole operation, with X and Y changed mid-operation -> exactly one DONE, and the result uses the operands sampled at edge 0. START high during the DONE cycle is ignored.
- X=0x80, Y=0x01 -> D=0x7F, B=0. With SERIAL_SUBTRACTOR_OVF_EN, OVF=1; without it, OVF=0. X=0x7F, Y=0xFF -> D=0x80, B=1, OVF=1 (enabled).
- Reset mid-operation: RST at edge 4 of an operation -> next cycle D=0, B=0, OVF=0, BUSY=0, DONE never pulses. A new START then completes normally.
- Exhaustive sweep at WIDTH=4 over all 256 (X, Y) pairs -> D = (X−Y) mod 16, B = (X<Y), compared against a reference model.
